// File: rtl/frame_capture_ctrl_pkg.sv
// Shared definitions for the frame capture controller and the frame buffer.
package frame_capture_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StCapture,
    StDone
  } state_e;

  localparam int unsigned DefHPixels = 320;
  localparam int unsigned DefVLines  = 240;

endpackage

// File: rtl/rise_edge_det.sv
// Rising-edge detector over a 2-bit registered history of an already-synchronized input.
module rise_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic [1:0] hist_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_q <= '0;
    end else begin
      hist_q <= {hist_q[0], d};
    end
  end

  assign rise = hist_q[0] & ~hist_q[1];

endmodule

// File: rtl/frame_capture_ctrl.sv
// Capture sequencer for one camera frame: arm, capture between two VSYNC rises, and
// emit linear frame-buffer writes with line truncation and frame overflow flags.
module frame_capture_ctrl
  import frame_capture_ctrl_pkg::*;
#(
  parameter int unsigned H_PIXELS = DefHPixels,
  parameter int unsigned V_LINES  = DefVLines,
  parameter int unsigned ADDR_W   = 17,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned LINE_W   = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              vsync,
  input  logic              href,
  input  logic              pix_valid,
  input  logic [DATA_W-1:0] pix_data,
  output logic              busy,
  output logic              done,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [LINE_W-1:0] lines_captured,
  output logic              err_hovf,
  output logic              err_vovf
);

  localparam int unsigned CntW = $clog2(H_PIXELS + 1);

  logic vs_re, hs_re, href_q;

  rise_edge_det u_vs_det (
    .clk   (clk),
    .reset (reset),
    .d     (vsync),
    .rise  (vs_re)
  );

  rise_edge_det u_hs_det (
    .clk   (clk),
    .reset (reset),
    .d     (href),
    .rise  (hs_re)
  );

  state_e            state_q, state_d;
  logic [LINE_W-1:0] lines_q, lines_d;
  logic [ADDR_W-1:0] line_base_q, line_base_d;
  logic [ADDR_W-1:0] next_base_q, next_base_d;
  logic [CntW-1:0]   pix_cnt_q, pix_cnt_d;
  logic              line_ok_q, line_ok_d;
  logic              err_hovf_q, err_hovf_d;
  logic              err_vovf_q, err_vovf_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  logic              in_cap, hs_go, room;
  logic              cur_ok;
  logic [CntW-1:0]   cur_cnt;
  logic [ADDR_W-1:0] cur_base;

  always_comb begin
    state_d     = state_q;
    lines_d     = lines_q;
    line_base_d = line_base_q;
    next_base_d = next_base_q;
    pix_cnt_d   = pix_cnt_q;
    line_ok_d   = line_ok_q;
    err_hovf_d  = err_hovf_q;
    err_vovf_d  = err_vovf_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;

    if (abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_d     = StArmed;
            lines_d     = '0;
            line_base_d = '0;
            next_base_d = '0;
            pix_cnt_d   = '0;
            line_ok_d   = 1'b0;
            err_hovf_d  = 1'b0;
            err_vovf_d  = 1'b0;
          end
        end
        StArmed:   if (vs_re) state_d = StCapture;
        StCapture: if (vs_re) state_d = StDone;
        StDone:    state_d = StIdle;
        default:   state_d = StIdle;
      endcase
    end

    // A VSYNC rise closes the frame, so a coincident HREF rise opens no new line.
    in_cap = (state_q == StCapture) && !abort && !vs_re;
    hs_go  = in_cap && hs_re;
    room   = lines_q < LINE_W'(V_LINES);

    // A pixel arriving in the HREF-rise cycle already belongs to the new line.
    cur_ok   = hs_go ? room        : line_ok_q;
    cur_cnt  = hs_go ? '0          : pix_cnt_q;
    cur_base = hs_go ? next_base_q : line_base_q;

    if (hs_go) begin
      pix_cnt_d = '0;
      if (room) begin
        line_ok_d   = 1'b1;
        line_base_d = next_base_q;
        next_base_d = next_base_q + ADDR_W'(H_PIXELS);
        lines_d     = lines_q + LINE_W'(1);
      end else begin
        line_ok_d  = 1'b0;
        err_vovf_d = 1'b1;
      end
    end

    if (in_cap && href_q && pix_valid && cur_ok) begin
      if (cur_cnt < CntW'(H_PIXELS)) begin
        wr_en_d   = 1'b1;
        wr_addr_d = cur_base + ADDR_W'(cur_cnt);
        wr_data_d = pix_data;
        pix_cnt_d = cur_cnt + CntW'(1);
      end else begin
        err_hovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      href_q      <= 1'b0;
      lines_q     <= '0;
      line_base_q <= '0;
      next_base_q <= '0;
      pix_cnt_q   <= '0;
      line_ok_q   <= 1'b0;
      err_hovf_q  <= 1'b0;
      err_vovf_q  <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      href_q      <= href;
      lines_q     <= lines_d;
      line_base_q <= line_base_d;
      next_base_q <= next_base_d;
      pix_cnt_q   <= pix_cnt_d;
      line_ok_q   <= line_ok_d;
      err_hovf_q  <= err_hovf_d;
      err_vovf_q  <= err_vovf_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  assign busy           = (state_q == StArmed) || (state_q == StCapture);
  assign done           = (state_q == StDone);
  assign wr_en          = wr_en_q;
  assign wr_addr        = wr_addr_q;
  assign wr_data        = wr_data_q;
  assign lines_captured = lines_q;
  assign err_hovf       = err_hovf_q;
  assign err_vovf       = err_vovf_q;

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Directed bench for frame_capture_ctrl with a 4x3 frame.
module tb_frame_capture_ctrl;

  localparam int H  = 4;
  localparam int V  = 3;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          vsync = 1'b0;
  logic          href = 1'b0;
  logic          pix_valid = 1'b0;
  logic [DW-1:0] pix_data = '0;
  logic          busy, done, wr_en, err_hovf, err_vovf;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [LW-1:0] lines_captured;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int done_base;

  logic [AW-1:0] wq_addr[$];
  logic [DW-1:0] wq_data[$];
  logic [AW-1:0] exp_addr[$];
  logic [DW-1:0] exp_data[$];

  always #5 clk = ~clk;

  frame_capture_ctrl #(
    .H_PIXELS (H),
    .V_LINES  (V),
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .LINE_W   (LW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .abort          (abort),
    .vsync          (vsync),
    .href           (href),
    .pix_valid      (pix_valid),
    .pix_data       (pix_data),
    .busy           (busy),
    .done           (done),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .lines_captured (lines_captured),
    .err_hovf       (err_hovf),
    .err_vovf       (err_vovf)
  );

  // Write and done logger, sampled away from the active edge.
  always @(negedge clk) begin
    if (wr_en) begin
      wq_addr.push_back(wr_addr);
      wq_data.push_back(wr_data);
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_q();
    wq_addr.delete();
    wq_data.delete();
    exp_addr.delete();
    exp_data.delete();
  endtask

  task automatic send_line(input int li, input int n);
    href = 1'b1;
    step();
    for (int p = 0; p < n; p++) begin
      pix_valid = 1'b1;
      pix_data  = DW'(16 * li + p);
      step();
    end
    pix_valid = 1'b0;
    href      = 1'b0;
    step();
    step();
  endtask

  task automatic expect_line(input int li, input int n);
    if (li < V) begin
      for (int p = 0; p < n && p < H; p++) begin
        exp_addr.push_back(AW'(li * H + p));
        exp_data.push_back(DW'(16 * li + p));
      end
    end
  endtask

  task automatic arm(input string tag);
    start = 1'b1;
    step();
    start = 1'b0;
    chk({tag, "_busy_armed"}, busy, 1);
    chk({tag, "_hovf_clr"}, err_hovf, 0);
    chk({tag, "_vovf_clr"}, err_vovf, 0);
    chk({tag, "_lines_clr"}, lines_captured, 0);
  endtask

  task automatic vs_start();
    vsync = 1'b1;
    step();
    step();
    vsync = 1'b0;
    step();
  endtask

  task automatic vs_end(input string tag);
    vsync = 1'b1;
    step();
    step();
    chk({tag, "_done_hi"}, done, 1);
    chk({tag, "_busy_lo"}, busy, 0);
    vsync = 1'b0;
    step();
    chk({tag, "_done_lo"}, done, 0);
  endtask

  task automatic chk_writes(input string tag);
    step();
    step();
    chk({tag, "_nwr"}, wq_addr.size(), exp_addr.size());
    for (int i = 0; i < wq_addr.size() && i < exp_addr.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), wq_addr[i], exp_addr[i]);
      chk($sformatf("%s_data%0d", tag, i), wq_data[i], exp_data[i]);
    end
  endtask

  task automatic run_frame(input string tag, input int nl, input int npx[5]);
    clear_q();
    arm(tag);
    vs_start();
    for (int li = 0; li < nl; li++) begin
      send_line(li, npx[li]);
      expect_line(li, npx[li]);
    end
    vs_end(tag);
    chk_writes(tag);
  endtask

  initial begin
    // Reset state
    step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_lines", lines_captured, 0);
    chk("rst_hovf", err_hovf, 0);
    chk("rst_vovf", err_vovf, 0);
    reset = 1'b1;
    step();

    run_frame("nom", 3, '{4, 4, 4, 0, 0});
    chk("nom_lines", lines_captured, 3);
    chk("nom_hovf", err_hovf, 0);
    chk("nom_vovf", err_vovf, 0);

    run_frame("long", 3, '{4, 6, 4, 0, 0});
    chk("long_lines", lines_captured, 3);
    chk("long_hovf", err_hovf, 1);
    chk("long_vovf", err_vovf, 0);

    run_frame("short", 2, '{2, 4, 0, 0, 0});
    chk("short_lines", lines_captured, 2);
    chk("short_hovf", err_hovf, 0);

    run_frame("extra", 5, '{4, 4, 4, 4, 4});
    chk("extra_lines", lines_captured, 3);
    chk("extra_vovf", err_vovf, 1);
    chk("extra_hovf", err_hovf, 0);

    // Abort partway through line 1
    clear_q();
    done_base = done_cnt;
    arm("abort");
    vs_start();
    send_line(0, 6);
    expect_line(0, 6);
    href = 1'b1;
    step();
    for (int p = 0; p < 2; p++) begin
      pix_valid = 1'b1;
      pix_data  = DW'(16 + p);
      step();
    end
    expect_line(1, 2);
    pix_data = DW'(18);
    abort    = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_hovf_kept", err_hovf, 1);
    chk("abort_lines", lines_captured, 2);
    step();
    step();
    pix_valid = 1'b0;
    href      = 1'b0;
    step();
    vsync = 1'b1;
    step();
    step();
    vsync = 1'b0;
    step();
    step();
    chk("abort_no_done", done_cnt - done_base, 0);
    chk_writes("abort");

    // Asynchronous reset mid-frame
    clear_q();
    arm("mrst");
    vs_start();
    send_line(0, 5);
    href = 1'b1;
    step();
    pix_valid = 1'b1;
    pix_data  = DW'(16);
    step();
    chk("mrst_pre_wr_en", wr_en, 1);
    chk("mrst_pre_addr", wr_addr, 4);
    chk("mrst_pre_lines", lines_captured, 2);
    chk("mrst_pre_hovf", err_hovf, 1);
    reset = 1'b0;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_wr_en", wr_en, 0);
    chk("mrst_wr_addr", wr_addr, 0);
    chk("mrst_wr_data", wr_data, 0);
    chk("mrst_lines", lines_captured, 0);
    chk("mrst_hovf", err_hovf, 0);
    chk("mrst_vovf", err_vovf, 0);
    pix_valid = 1'b0;
    href      = 1'b0;
    step();
    reset = 1'b1;
    step();
    run_frame("after_rst", 3, '{4, 4, 4, 0, 0});
    chk("after_rst_lines", lines_captured, 3);

    // Arming with vsync already high: capture waits for a fresh rise
    clear_q();
    vsync = 1'b1;
    step();
    step();
    start = 1'b1;
    step();
    step();
    chk("armhi_busy", busy, 1);
    send_line(0, 4);
    chk("armhi_lines", lines_captured, 0);
    chk("armhi_nowr", wq_addr.size(), 0);
    vsync = 1'b0;
    step();
    vsync = 1'b1;
    step();
    step();
    start = 1'b0;
    vsync = 1'b0;
    step();
    send_line(0, 4);
    expect_line(0, 4);
    vs_end("armhi");
    chk_writes("armhi");
    chk("armhi_lines_end", lines_captured, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
